// File: rtl/actuator_cmd_arbiter.sv
// Three-requester arbiter for the actuator command bus: emergency requester 0 always wins,
// requesters 1/2 share the bus round-robin with a minimum hold time and a one-cycle guard gap.
module actuator_cmd_arbiter #(
    parameter int unsigned HOLD_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0,
    input  logic [5:0] req0_cmd,
    input  logic       req1,
    input  logic [5:0] req1_cmd,
    input  logic       req2,
    input  logic [5:0] req2_cmd,
    output logic [2:0] grant,
    output logic [1:0] acceleration,
    output logic [1:0] steering,
    output logic [1:0] indicators,
    output logic       busy,
    output logic [7:0] preempt_count
);

    localparam int unsigned CMD_W = 6;
    localparam int unsigned CNT_W = 4;
    localparam int unsigned PC_W  = 8;
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [PC_W-1:0]  PC_MAX    = '1;

    typedef struct packed {
        logic [1:0] accel;
        logic [1:0] steer;
        logic [1:0] ind;
    } cmd_t;

    localparam cmd_t SAFE_CMD = cmd_t'(CMD_W'(6'b01_00_00));

    typedef enum logic [1:0] {IDLE, GRANT, GUARD} state_t;

    state_t           state;
    cmd_t             cmd_q;
    logic [CNT_W-1:0] hold_cnt;
    logic             rr_last2;   // 1: requester 2 was served last among {1,2}

    logic [2:0] pick_c;
    cmd_t       pick_cmd_c;
    cmd_t       owner_cmd_c;
    logic       owner_req_c;
    logic       other_req_c;

    function automatic cmd_t sel_cmd(input logic [2:0] sel, input logic [5:0] c0,
                                     input logic [5:0] c1, input logic [5:0] c2);
        cmd_t r;
        r = cmd_t'(c0);
        if (sel[1]) r = cmd_t'(c1);
        if (sel[2]) r = cmd_t'(c2);
        return r;
    endfunction

    // Winner for a fresh arbitration out of IDLE
    always_comb begin
        pick_c = 3'b000;
        if (req0)              pick_c = 3'b001;
        else if (req1 && req2) pick_c = rr_last2 ? 3'b010 : 3'b100;
        else if (req1)         pick_c = 3'b010;
        else if (req2)         pick_c = 3'b100;
    end

    always_comb begin
        pick_cmd_c  = sel_cmd(pick_c, req0_cmd, req1_cmd, req2_cmd);
        owner_cmd_c = sel_cmd(grant, req0_cmd, req1_cmd, req2_cmd);
        owner_req_c = |(grant & {req2, req1, req0});
        other_req_c = grant[1] ? req2 : req1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            grant         <= 3'b000;
            cmd_q         <= SAFE_CMD;
            hold_cnt      <= '0;
            preempt_count <= '0;
            rr_last2      <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (|pick_c) begin
                        state    <= GRANT;
                        grant    <= pick_c;
                        cmd_q    <= pick_cmd_c;
                        hold_cnt <= HOLD_LOAD;
                        if (pick_c[1]) rr_last2 <= 1'b0;
                        if (pick_c[2]) rr_last2 <= 1'b1;
                    end
                end
                GRANT: begin
                    if (req0 && !grant[0]) begin
                        grant    <= 3'b001;
                        cmd_q    <= cmd_t'(req0_cmd);
                        hold_cnt <= HOLD_LOAD;
                        if (preempt_count != PC_MAX) preempt_count <= preempt_count + PC_W'(1);
                    end else if (!owner_req_c ||
                                 (!grant[0] && hold_cnt == '0 && other_req_c)) begin
                        state <= GUARD;
                        grant <= 3'b000;
                        cmd_q <= SAFE_CMD;
                    end else begin
                        cmd_q <= owner_cmd_c;
                        if (hold_cnt != '0) hold_cnt <= hold_cnt - CNT_W'(1);
                    end
                end
                GUARD: begin
                    if (req0) begin
                        state    <= GRANT;
                        grant    <= 3'b001;
                        cmd_q    <= cmd_t'(req0_cmd);
                        hold_cnt <= HOLD_LOAD;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    grant <= 3'b000;
                    cmd_q <= SAFE_CMD;
                end
            endcase
        end
    end

    assign busy         = (state != IDLE);
    assign acceleration = cmd_q.accel;
    assign steering     = cmd_q.steer;
    assign indicators   = cmd_q.ind;

endmodule

// File: tb/tb_actuator_cmd_arbiter.sv
// Directed bench for actuator_cmd_arbiter; values checked one time unit after each rising edge.
module tb_actuator_cmd_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0, req1, req2;
    logic [5:0] req0_cmd, req1_cmd, req2_cmd;
    logic [2:0] grant;
    logic [1:0] acceleration, steering, indicators;
    logic       busy;
    logic [7:0] preempt_count;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_pc;

    actuator_cmd_arbiter #(.HOLD_CYCLES(4)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req0_cmd(req0_cmd),
        .req1(req1), .req1_cmd(req1_cmd),
        .req2(req2), .req2_cmd(req2_cmd),
        .grant(grant), .acceleration(acceleration), .steering(steering),
        .indicators(indicators), .busy(busy), .preempt_count(preempt_count)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_safe(input string tag);
        check_eq({tag, "_grant"}, 32'(grant), 32'h0);
        check_eq({tag, "_accel"}, 32'(acceleration), 32'h1);
        check_eq({tag, "_steer"}, 32'(steering), 32'h0);
        check_eq({tag, "_ind"},   32'(indicators), 32'h0);
    endtask

    initial begin
        // Reset with every requester asking
        rst = 1'b1; req0 = 1'b1; req1 = 1'b1; req2 = 1'b1;
        req0_cmd = 6'b111111; req1_cmd = 6'b111111; req2_cmd = 6'b111111;
        tick(); tick();
        check_safe("reset");
        check_eq("reset_busy", 32'(busy), 32'h0);
        check_eq("reset_pc", 32'(preempt_count), 32'h0);

        // Lone requester 1: grant, follow, release through GUARD
        req0 = 1'b0; req1 = 1'b0; req2 = 1'b0;
        rst = 1'b0;
        tick();
        check_eq("idle_busy", 32'(busy), 32'h0);
        req1 = 1'b1; req1_cmd = 6'b100000;
        tick();                                           // cycle 1
        check_eq("r1_grant", 32'(grant), 32'h2);
        check_eq("r1_accel", 32'(acceleration), 32'h2);
        check_eq("r1_busy", 32'(busy), 32'h1);
        req1_cmd = 6'b011110;
        tick();                                           // cycle 2
        check_eq("r1_follow_accel", 32'(acceleration), 32'h1);
        check_eq("r1_follow_steer", 32'(steering), 32'h3);
        check_eq("r1_follow_ind", 32'(indicators), 32'h2);
        tick(); tick(); tick();                           // cycles 3-5
        check_eq("r1_stay", 32'(grant), 32'h2);
        req1 = 1'b0;
        tick();                                           // cycle 6: GUARD
        check_safe("r1_guard");
        check_eq("r1_guard_busy", 32'(busy), 32'h1);
        tick();                                           // cycle 7: IDLE
        check_eq("r1_idle_busy", 32'(busy), 32'h0);

        // Fairness handover between 1 and 2 after HOLD_CYCLES
        rst = 1'b1; tick(); rst = 1'b0;
        req1 = 1'b1; req2 = 1'b1; req1_cmd = 6'b100000; req2_cmd = 6'b100101;
        for (int c = 1; c <= 4; c++) begin
            tick();
            check_eq($sformatf("fair_g1_c%0d", c), 32'(grant), 32'h2);
        end
        tick();                                           // cycle 5
        check_eq("fair_guard_grant", 32'(grant), 32'h0);
        check_eq("fair_guard_busy", 32'(busy), 32'h1);
        tick();                                           // cycle 6
        check_eq("fair_idle_busy", 32'(busy), 32'h0);
        tick();                                           // cycle 7
        check_eq("fair_g2", 32'(grant), 32'h4);
        check_eq("fair_g2_accel", 32'(acceleration), 32'h2);
        check_eq("fair_g2_steer", 32'(steering), 32'h1);
        check_eq("fair_g2_ind", 32'(indicators), 32'h1);

        // Emergency preemption of owner 2
        req0 = 1'b1; req0_cmd = 6'b000000;
        tick();
        check_eq("pre_grant", 32'(grant), 32'h1);
        check_eq("pre_accel", 32'(acceleration), 32'h0);
        check_eq("pre_steer", 32'(steering), 32'h0);
        check_eq("pre_pc", 32'(preempt_count), 32'h1);
        for (int c = 0; c < 6; c++) tick();
        check_eq("owner0_kept", 32'(grant), 32'h1);
        check_eq("owner0_pc", 32'(preempt_count), 32'h1);

        // Saturation: repeated release / regrant of 1 / preempt
        req2 = 1'b0;
        exp_pc = 1;
        for (int i = 0; i < 300; i++) begin
            req0 = 1'b0;
            tick(); tick(); tick();                       // GUARD, IDLE, GRANT owner 1
            req0 = 1'b1;
            tick();
            exp_pc = (exp_pc < 255) ? exp_pc + 1 : 255;
            if (exp_pc == 254 && i == 252)
                check_eq("sat_pc_254", 32'(preempt_count), 32'd254);
        end
        check_eq("sat_pc_255", 32'(preempt_count), 32'(exp_pc));
        check_eq("sat_grant", 32'(grant), 32'h1);

        // Reset pulse while owner 2 holds the bus
        req0 = 1'b0; req1 = 1'b0; req2 = 1'b0;
        rst = 1'b1; tick(); rst = 1'b0;
        req2 = 1'b1;
        tick();
        check_eq("rst2_owner2", 32'(grant), 32'h4);
        rst = 1'b1;
        tick();
        check_safe("rst2_mid");
        check_eq("rst2_busy", 32'(busy), 32'h0);
        rst = 1'b0; req1 = 1'b1;
        tick();
        check_eq("rst2_tie_r1", 32'(grant), 32'h2);

        // req0 arriving during GUARD: no preempt count
        req1 = 1'b0; req2 = 1'b0;
        tick();
        check_eq("guard_grant", 32'(grant), 32'h0);
        check_eq("guard_busy", 32'(busy), 32'h1);
        req0 = 1'b1; req0_cmd = 6'b001010;
        tick();
        check_eq("guard_r0_grant", 32'(grant), 32'h1);
        check_eq("guard_r0_steer", 32'(steering), 32'h2);
        check_eq("guard_r0_ind", 32'(indicators), 32'h2);
        check_eq("guard_r0_pc", 32'(preempt_count), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/actuator_cmd_arbiter.md
ACTUATOR_CMD_ARBITER -- requirements
Module: actuator_cmd_arbiter

Interface
REQ-001 Parameter: HOLD_CYCLES, default 4, minimum cycles of ownership before a fairness handover (legal range 1..15).
REQ-002 clk  input  1  system clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 req0  input  1  emergency requester (collision stop) asks for the actuator bus.
REQ-005 req0_cmd  input  6  {acceleration[1:0], steering[1:0], indicators[1:0]} from requester 0.
REQ-006 req1 / req1_cmd  input  1 / 6  navigation requester, same packing.
REQ-007 req2 / req2_cmd  input  1 / 6  lane-manoeuvre requester, same packing.
REQ-008 grant  output  3  one-hot owner; bit n = requester n; 000 = no owner.
REQ-009 acceleration  output  2  registered command to the datapath (01 = coast).
REQ-010 steering  output  2  registered steering command.
REQ-011 indicators  output  2  registered indicator command.
REQ-012 busy  output  1  high whenever state is not IDLE.
REQ-013 preempt_count  output  8  saturating count of emergency preemptions.

Function
REQ-014 States SHALL be IDLE, GRANT, GUARD; all outputs registered.
REQ-015 Safe command SHALL be acceleration=01, steering=00, indicators=00; driven in IDLE and GUARD with grant=000.
REQ-016 Arbitration: req0 always wins; otherwise req1 vs req2 by round-robin pointer (the one not served last wins a tie); a lone requester wins.
REQ-017 IDLE: any req at edge N SHALL set state=GRANT, grant=winner, command outputs=winner's cmd, and hold_cnt=HOLD_CYCLES-1 at edge N+1 (one-cycle latency).
REQ-018 Granting requester 1 or 2 SHALL update the round-robin pointer to that requester; granting 0 SHALL leave it unchanged.
REQ-019 GRANT: command outputs SHALL follow the owner's cmd with one-cycle latency every cycle.
REQ-020 GRANT: hold_cnt SHALL decrement by 1 per cycle while nonzero and hold at 0.
REQ-021 GRANT priority per cycle (highest first): preempt, voluntary release, fairness handover, stay.
REQ-022 Preempt: req0 high and owner!=0 -> next edge grant=001, commands=req0_cmd, hold_cnt reloaded, no GUARD cycle, preempt_count +1 (saturating at 255).
REQ-023 Voluntary release: owner's req low (any hold_cnt value) -> GUARD next edge.
REQ-024 Fairness handover: owner is 1 or 2, hold_cnt==0, owner still requesting, other of {1,2} requesting -> GUARD next edge.
REQ-025 Owner 0 SHALL never be handed over for fairness; it keeps the bus until req0 drops.
REQ-026 GUARD SHALL last exactly one cycle; with req0 high it SHALL go to GRANT owner 0 (no preempt_count change), otherwise to IDLE.
REQ-027 In IDLE after GUARD, arbitration per REQ-016 SHALL apply, so a handed-over requester regains the bus only if the other has dropped.
REQ-028 HOLD_CYCLES=1 SHALL load hold_cnt=0, permitting a handover on the first GRANT cycle.
REQ-029 grant SHALL always be one-hot or zero; busy=0 exactly when state=IDLE.

Reset
REQ-030 With rst high at an edge: state=IDLE, grant=000, safe command, busy=0, hold_cnt=0, preempt_count=0, round-robin pointer=requester 2 (so requester 1 wins the first tie); applies mid-operation, overriding all requests.

Verification
REQ-031 rst high 2 cycles with all reqs high -> grant=000, acceleration=01, steering=00, indicators=00, busy=0, preempt_count=0.
REQ-032 req1 rises at cycle 0 with cmd 100000 -> cycle 1 grant=010, acceleration=10; req1 drops at cycle 5 -> cycle 6 grant=000, safe command (GUARD); cycle 7 busy=0.
REQ-033 HOLD_CYCLES=4, req1 and req2 high from cycle 0 -> grant=010 cycles 1-4, GUARD cycle 5, IDLE cycle 6, grant=100 cycle 7.
REQ-034 Owner 2 with cmd 100101, req0 rises with cmd 000000 -> next cycle grant=001, acceleration=00, steering=00, preempt_count=1; 300 preemptions -> preempt_count=255.
REQ-035 rst pulsed for one cycle while owner=2 in GRANT -> next cycle safe command, grant=000; then req1 and req2 both high -> grant=010.
REQ-036 req0 rises during GUARD -> next cycle grant=001, preempt_count unchanged.
